lcd_text_driver: RTL and testbench

Parametrised character-LCD driver for HD44780-compatible panels. It folds the slow-clock divider into an internal clock-enable, so the whole block runs on the single system clock. It holds a ROWS×COLS character buffer that the rest of the design writes through a simple write port, and after a fixed init sequence it refreshes the panel continuously. It replaces the fixed 16×2, scene-specific controller pairing so that any board-level text source can drive any supported panel geometry.

---
 rtl/lcd_pkg.sv | 36 +++
 rtl/lcd_tick_gen.sv | 29 ++
 rtl/lcd_text_driver.sv | 182 ++++++++++++++++++
 tb/tb_lcd_text_driver.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - HD44780 command bytes, row base addresses and FSM states for lcd_text_driver
package lcd_pkg;

  localparam logic [7:0] FUNC_8B2L = 8'h38;
  localparam logic [7:0] DISP_ON   = 8'h0C;
  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] ENTRY_INC = 8'h06;
  localparam logic [7:0] SET_DDRAM = 8'h80;

  typedef enum logic [1:0] {
    ST_PWR,
    ST_INIT,
    ST_ROW_ADDR,
    ST_CHAR
  } lcd_state_e;

  // Rows 2 and 3 of a 4-line panel continue rows 0 and 1 in DDRAM.
  function automatic logic [6:0] row_base(input logic [1:0] row, input logic [6:0] cols);
    case (row)
      2'd0:    row_base = 7'h00;
      2'd1:    row_base = 7'h40;
      2'd2:    row_base = cols;
      default: row_base = 7'h40 + cols;
    endcase
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = FUNC_8B2L;
      2'd1:    init_cmd = DISP_ON;
      2'd2:    init_cmd = CLEAR;
      default: init_cmd = ENTRY_INC;
    endcase
  endfunction

endpackage

// File: rtl/lcd_tick_gen.sv
// rtl/lcd_tick_gen.sv - one-clk step enable every CLK_HZ/TICK_HZ system clocks
module lcd_tick_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 400
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/lcd_text_driver.sv
// rtl/lcd_text_driver.sv - ROWS x COLS text buffer continuously refreshed onto an HD44780 panel
module lcd_text_driver
  import lcd_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 400,
  parameter int COLS     = 16,
  parameter int ROWS     = 2,
  parameter int PWR_WAIT = 20
) (
  input  logic                                     clk,
  input  logic                                     resetn,
  input  logic                                     wr_en,
  input  logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] wr_row,
  input  logic [$clog2(COLS):0]                    wr_col,
  input  logic [7:0]                               wr_char,
  output logic                                     ready,
  output logic                                     frame_done,
  output logic                                     LCD_ON,
  output logic                                     LCD_RS,
  output logic                                     LCD_EN,
  output logic                                     LCD_RW,
  output logic [7:0]                               LCD_DATA
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = $clog2(COLS) + 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [15:0]      PWR_LAST = 16'(PWR_WAIT - 1);

  logic w_tick;

  lcd_tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .tick   (w_tick)
  );

  logic [7:0]       r_buf [ROWS][COLS];
  lcd_state_e       r_state, w_state;
  logic             r_hold, w_hold;
  logic [15:0]      r_pwr_cnt, w_pwr_cnt;
  logic [1:0]       r_init_idx, w_init_idx;
  logic [ROW_W-1:0] r_row, w_row;
  logic [COL_W-1:0] r_col, w_col;
  logic             r_en, w_en, r_rs, w_rs, r_on;
  logic             r_ready, w_ready, r_frame_done, w_frame_done;
  logic [7:0]       r_data, w_data, w_rd_char;

  // Out-of-range addresses match no cell, so they are dropped without extra decode.
  always_ff @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (!resetn) begin
          r_buf[r][c] <= 8'h20;
        end else if (wr_en && wr_row == r[ROW_W-1:0] && wr_col == c[COL_W-1:0]) begin
          r_buf[r][c] <= wr_char;
        end
      end
    end
  end

  // A write landing on the SETUP edge itself must still reach this frame.
  always_comb begin
    w_rd_char = 8'h20;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (r_row == r[ROW_W-1:0] && r_col == c[COL_W-1:0]) begin
          w_rd_char = r_buf[r][c];
        end
      end
    end
    if (wr_en && wr_row == r_row && wr_col == r_col) begin
      w_rd_char = wr_char;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_hold       = r_hold;
    w_pwr_cnt    = r_pwr_cnt;
    w_init_idx   = r_init_idx;
    w_row        = r_row;
    w_col        = r_col;
    w_en         = r_en;
    w_rs         = r_rs;
    w_data       = r_data;
    w_ready      = r_ready;
    w_frame_done = 1'b0;
    if (w_tick) begin
      if (r_state == ST_PWR) begin
        if (r_pwr_cnt == PWR_LAST) begin
          w_state   = ST_INIT;
          w_pwr_cnt = '0;
        end else begin
          w_pwr_cnt = r_pwr_cnt + 16'd1;
        end
      end else begin
        w_hold = ~r_hold;
        w_en   = ~r_hold;
        if (!r_hold) begin
          w_rs = (r_state == ST_CHAR);
          case (r_state)
            ST_INIT:     w_data = init_cmd(r_init_idx);
            ST_ROW_ADDR: w_data = SET_DDRAM | {1'b0, row_base(2'(r_row), 7'(COLS))};
            default:     w_data = w_rd_char;
          endcase
        end else begin
          case (r_state)
            ST_INIT: begin
              if (r_init_idx == 2'd3) begin
                w_state = ST_ROW_ADDR;
                w_row   = '0;
                w_ready = 1'b1;
              end else begin
                w_init_idx = r_init_idx + 2'd1;
              end
            end
            ST_ROW_ADDR: begin
              w_state = ST_CHAR;
              w_col   = '0;
            end
            default: begin
              if (r_col == COL_LAST) begin
                w_col   = '0;
                w_state = ST_ROW_ADDR;
                if (r_row == ROW_LAST) begin
                  w_row        = '0;
                  w_frame_done = 1'b1;
                end else begin
                  w_row = r_row + 1'b1;
                end
              end else begin
                w_col = r_col + 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= ST_PWR;
      r_hold       <= 1'b0;
      r_pwr_cnt    <= '0;
      r_init_idx   <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_en         <= 1'b0;
      r_rs         <= 1'b0;
      r_data       <= 8'h00;
      r_on         <= 1'b0;
      r_ready      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_hold       <= w_hold;
      r_pwr_cnt    <= w_pwr_cnt;
      r_init_idx   <= w_init_idx;
      r_row        <= w_row;
      r_col        <= w_col;
      r_en         <= w_en;
      r_rs         <= w_rs;
      r_data       <= w_data;
      r_on         <= 1'b1;
      r_ready      <= w_ready;
      r_frame_done <= w_frame_done;
    end
  end

  assign ready      = r_ready;
  assign frame_done = r_frame_done;
  assign LCD_ON     = r_on;
  assign LCD_RS     = r_rs;
  assign LCD_EN     = r_en;
  assign LCD_RW     = 1'b0;
  assign LCD_DATA   = r_data;

endmodule

// File: tb/tb_lcd_text_driver.sv
// tb/tb_lcd_text_driver.sv - self-checking bench for lcd_text_driver (2x16 and 4x20, DIV=4)
module tb_lcd_text_driver;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic wr_en = 1'b0;
  logic [0:0] wr_row = '0;
  logic [4:0] wr_col = '0;
  logic [7:0] wr_char = '0;
  logic ready, frame_done, lcd_on, lcd_rs, lcd_en, lcd_rw;
  logic [7:0] lcd_data;
  logic wr_en4 = 1'b0;
  logic [1:0] wr_row4 = '0;
  logic [5:0] wr_col4 = '0;
  logic [7:0] wr_char4 = '0;
  logic ready4, fd4, on4, rs4, en4, rw4;
  logic [7:0] data4;

  always #5 clk = ~clk;

  lcd_text_driver #(.CLK_HZ(40), .TICK_HZ(10), .COLS(16), .ROWS(2), .PWR_WAIT(20)) u_dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_char(wr_char), .ready(ready), .frame_done(frame_done), .LCD_ON(lcd_on),
    .LCD_RS(lcd_rs), .LCD_EN(lcd_en), .LCD_RW(lcd_rw), .LCD_DATA(lcd_data));

  lcd_text_driver #(.CLK_HZ(40), .TICK_HZ(10), .COLS(20), .ROWS(4), .PWR_WAIT(20)) u_dut4 (
    .clk(clk), .resetn(resetn), .wr_en(wr_en4), .wr_row(wr_row4), .wr_col(wr_col4),
    .wr_char(wr_char4), .ready(ready4), .frame_done(fd4), .LCD_ON(on4),
    .LCD_RS(rs4), .LCD_EN(en4), .LCD_RW(rw4), .LCD_DATA(data4));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rel = 0;
  int pos = 0;
  int p4 = 0;
  int fd_last = -1;
  int f4 = -1;
  logic en_q = 1'b0;
  logic e4q = 1'b0;
  logic [8:0] held = '0;
  logic [7:0] mdl [2][16];
  logic [7:0] seen [2][16];

  typedef struct {
    logic [0:0] row;
    logic [4:0] col;
    logic [7:0] ch;
    int         er;
    int         ec;
    logic [7:0] exp;
  } wvec_t;
  wvec_t tbl [6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [8:0] init_byte(input int p);
    case (p)
      0:       return 9'h038;
      1:       return 9'h00C;
      2:       return 9'h001;
      default: return 9'h006;
    endcase
  endfunction

  function automatic logic [8:0] addr_byte(input int r, input int cols);
    return {1'b0, 8'(128 + (r % 2) * 64 + (r / 2) * cols)};
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 16; c++) mdl[r][c] = 8'h20;
  endtask

  task automatic wr(input logic [0:0] r, input logic [4:0] c, input logic [7:0] ch);
    wr_en = 1'b1; wr_row = r; wr_col = c; wr_char = ch;
    @(posedge clk); #1;
    if (c < 16) mdl[r][c] = ch;
    wr_en = 1'b0;
  endtask

  // Byte stream model: each EN rise is compared with the byte the panel should get next.
  initial begin : mon2x16
    int k, r, c;
    logic [8:0] exp;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        pos = 0; en_q = 1'b0; fd_last = -1;
      end else begin
        if (lcd_en && !en_q) begin
          if (pos < 4) begin
            exp = init_byte(pos);
          end else begin
            k = (pos - 4) % 34; r = k / 17; c = k % 17;
            if (c == 0) exp = addr_byte(r, 16);
            else begin
              exp = {1'b1, mdl[r][c-1]};
              seen[r][c-1] = lcd_data;
            end
          end
          chk("byte", {lcd_rs, lcd_data}, exp);
          chk("rw_on", {lcd_rw, lcd_on}, 2'b01);
          chk("ready_lvl", ready, (pos >= 4) ? 1 : 0);
          held = {lcd_rs, lcd_data};
          pos++;
        end
        if (!lcd_en && en_q) chk("hold_stable", {lcd_rs, lcd_data}, held);
        if (frame_done) begin
          chk("fd_align", (pos > 4 && (pos - 4) % 34 == 0 && !lcd_en && en_q) ? 1 : 0, 1);
          if (fd_last >= 0) chk("fd_period", cyc - fd_last, 272);
          fd_last = cyc;
        end
        en_q = lcd_en;
      end
    end
  end

  initial begin : mon4x20
    int k, r, c;
    logic [8:0] exp;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        p4 = 0; e4q = 1'b0; f4 = -1;
      end else begin
        if (en4 && !e4q) begin
          if (p4 < 4) exp = init_byte(p4);
          else begin
            k = (p4 - 4) % 84; r = k / 21; c = k % 21;
            exp = (c == 0) ? addr_byte(r, 20) : 9'h120;
          end
          chk("byte4", {rs4, data4}, exp);
          p4++;
        end
        if (fd4) begin
          if (f4 >= 0) chk("fd4_period", cyc - f4, 672);
          f4 = cyc;
        end
        e4q = en4;
      end
    end
  end

  task automatic wait_fd();
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (frame_done) break;
    end
    chk("fd_wait", (i < 400) ? 1 : 0, 1);
  endtask

  task automatic wait_pos(input int k);
    int i;
    int p0;
    p0 = pos;
    for (i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (pos != p0 && pos > 4 && (pos - 5) % 34 == k) break;
      p0 = pos;
    end
    chk("pos_wait", (i < 400) ? 1 : 0, 1);
  endtask

  task automatic start_run(input bit do_table);
    int i;
    @(negedge clk);
    resetn = 1'b1;
    rel = cyc;
    @(negedge clk); #1;
    chk("after_release", {lcd_on, ready, lcd_en}, 3'b100);
    if (do_table)
      for (int t = 0; t < 6; t++) wr(tbl[t].row, tbl[t].col, tbl[t].ch);
    for (i = 0; i < 200; i++) begin
      if (lcd_en) break;
      @(negedge clk); #1;
    end
    chk("first_en_edge", cyc - rel, 84);
    chk("first_byte", {lcd_rs, lcd_data}, 9'h038);
    for (i = 0; i < 100; i++) begin
      if (ready) break;
      @(negedge clk); #1;
    end
    chk("ready_edge", cyc - rel, 112);
  endtask

  initial begin
    tbl[0] = '{1'b0, 5'd0,  8'h41, 0, 0,  8'h41};
    tbl[1] = '{1'b1, 5'd15, 8'h5A, 1, 15, 8'h5A};
    tbl[2] = '{1'b0, 5'd16, 8'h51, 0, 0,  8'h41};
    tbl[3] = '{1'b1, 5'd31, 8'h71, 1, 15, 8'h5A};
    tbl[4] = '{1'b1, 5'd3,  8'h37, 1, 3,  8'h37};
    tbl[5] = '{1'b0, 5'd20, 8'h78, 0, 4,  8'h20};
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vals", {lcd_en, lcd_rs, lcd_rw, lcd_on, ready, frame_done, lcd_data}, 0);
    chk("reset_vals4", {en4, rs4, rw4, on4, ready4, fd4, data4}, 0);

    start_run(1'b1);
    wait_fd();
    for (int t = 0; t < 6; t++) chk("table_cell", seen[tbl[t].er][tbl[t].ec], tbl[t].exp);
    wait_fd();

    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      wr(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom));
    end
    wait_fd();
    wait_fd();

    // Write landing exactly on the SETUP edge of cell (0,5): shown in this frame.
    wait_pos(5);
    repeat (7) @(negedge clk);
    wr(1'b0, 5'd5, 8'h61);
    @(negedge clk); #1;
    chk("collide_now", seen[0][5], 8'h61);
    // One clk later: old char now, new char next frame.
    wait_pos(5);
    repeat (8) @(negedge clk);
    wr(1'b0, 5'd5, 8'h62);
    chk("collide_late_old", seen[0][5], 8'h61);
    wait_pos(6);
    chk("collide_late_new", seen[0][5], 8'h62);

    begin : mid_reset
      int i;
      for (i = 0; i < 200; i++) begin
        @(negedge clk); #1;
        if (lcd_en && lcd_rs) break;
      end
      chk("char_en_wait", (i < 200) ? 1 : 0, 1);
    end
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("reset_mid", {lcd_en, lcd_rs, lcd_on, ready, frame_done, lcd_data}, 0);
    repeat (2) @(posedge clk);
    clear_model();
    start_run(1'b0);
    wait_fd();
    wait_fd();
    chk("dut4_status", {ready4, on4, rw4}, 3'b110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1);
  end

endmodule
